// File: rtl/logic_pkg.sv
// Shared operation encoding for the logic slice and anything that reuses logic_core.
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_NAND = 3'b001,
        OP_OR   = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

endpackage

// File: rtl/logic_core.sv
// Purely combinational bitwise function f(op, a, y); y is ignored for NOT and PASS.
module logic_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = a;
        case (op)
            OP_AND:  res = a & y;
            OP_NAND: res = ~(a & y);
            OP_OR:   res = a | y;
            OP_NOR:  res = ~(a | y);
            OP_XOR:  res = a ^ y;
            OP_XNOR: res = ~(a ^ y);
            OP_NOT:  res = ~a;
            OP_PASS: res = a;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_nb.sv
// Registered logic slice: one-stage valid/ready pipe with an optional accumulator
// that folds a stream of right operands into a running result.
module logic_unit_nb
    import logic_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] acc_cnt
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    // Ready depends only on the output register state, never on in_valid or data.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A clear on an accumulate beat seeds from x instead of the stale accumulator.
    assign a = (acc_mode && !acc_clr) ? acc : x;

    assign cnt_inc = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1);

    logic_core #(.WIDTH(WIDTH)) u_core (
        .op  (op_t'(op)),
        .a   (a),
        .y   (y),
        .res (res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b1;
            ones      <= 1'b0;
            acc       <= '0;
            acc_cnt   <= '0;
        end else if (accept) begin
            out       <= res;
            zero      <= (res == '0);
            ones      <= (&res);
            out_valid <= 1'b1;
            if (acc_mode) begin
                acc     <= res;
                acc_cnt <= acc_clr ? CNT_W'(1) : cnt_inc;
            end
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (acc_clr) begin
                acc     <= '0;
                acc_cnt <= '0;
            end
        end
    end

endmodule
